// File: rtl/c499_sec_pkg.sv
// Shared widths, the c499 check-bit coverage masks, and a reference check-bit function.
package c499_sec_pkg;

    localparam int DATA_W  = 32;
    localparam int CHECK_W = 8;

    // Index k selects the data bits that are XORed into check bit Ck.
    localparam logic [CHECK_W-1:0][DATA_W-1:0] CHK_MASK = {
        32'h8888_F0F0,  // C7
        32'h4444_0F0F,  // C6
        32'h2222_FF00,  // C5
        32'h1111_00FF,  // C4
        32'hF0F0_8888,  // C3
        32'h0F0F_4444,  // C2
        32'hFF00_2222,  // C1
        32'h00FF_1111   // C0
    };

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [3:0]        byte_par;
        logic [7:0]        nib_par;
        logic [3:0]        col_par;
    } s1_t;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [CHECK_W-1:0] check;
    } s2_t;

    function automatic logic [CHECK_W-1:0] sec_check(input logic [DATA_W-1:0] data);
        logic [CHECK_W-1:0] c;
        for (int k = 0; k < CHECK_W; k++) begin
            c[k] = ^(data & CHK_MASK[k]);
        end
        return c;
    endfunction

endpackage

// File: rtl/c499_sec_stage.sv
// Generic valid/ready pipeline register; one cycle latency.
// Loads when empty or when the consumer takes the held word, so it never stalls a free slot.
module c499_sec_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/c499_sec_encoder.sv
// c499 check-bit encoder: two-stage valid/ready pipeline, 2-cycle latency, full throughput.
// in_ready falls only with both stages full and out_ready low; SEC_KEY_LOCK_EN adds an XOR key on the check bits.
import c499_sec_pkg::*;

module c499_sec_encoder #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
`ifdef SEC_KEY_LOCK_EN
    input  logic [7:0]         key,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [CHECK_W-1:0] out_check,
    output logic [CNT_W-1:0]   word_count,
    output logic               busy
);

    s1_t                s1_d, s1_q;
    s2_t                s2_d, s2_q;
    logic               s1_valid, s2_valid, s2_ready;
    logic [3:0]         low_col, high_col;
    logic [CHECK_W-1:0] chk;

    // Stage 1: partial parities over bytes, nibbles and bit columns.
    always_comb begin
        s1_d.data     = in_data;
        s1_d.byte_par = '0;
        s1_d.nib_par  = '0;
        s1_d.col_par  = '0;
        for (int b = 0; b < 4; b++) begin
            s1_d.byte_par[b] = ^in_data[8*b +: 8];
        end
        for (int n = 0; n < 8; n++) begin
            s1_d.nib_par[n] = ^in_data[4*n +: 4];
        end
        for (int i = 0; i < DATA_W; i++) begin
            s1_d.col_par[i % 4] = s1_d.col_par[i % 4] ^ in_data[i];
        end
    end

    c499_sec_stage #(.W($bits(s1_t))) u_stage1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_d),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_q)
    );

    // Columns split into the low half-word (bits 0..15) and the rest, recovered from the full column parity.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            low_col[k] = s1_q.data[k] ^ s1_q.data[k+4] ^ s1_q.data[k+8] ^ s1_q.data[k+12];
        end
        high_col = s1_q.col_par ^ low_col;
        chk[0] = low_col[0]  ^ s1_q.byte_par[2];
        chk[1] = low_col[1]  ^ s1_q.byte_par[3];
        chk[2] = low_col[2]  ^ s1_q.nib_par[4] ^ s1_q.nib_par[6];
        chk[3] = low_col[3]  ^ s1_q.nib_par[5] ^ s1_q.nib_par[7];
        chk[4] = high_col[0] ^ s1_q.byte_par[0];
        chk[5] = high_col[1] ^ s1_q.byte_par[1];
        chk[6] = high_col[2] ^ s1_q.nib_par[0] ^ s1_q.nib_par[2];
        chk[7] = high_col[3] ^ s1_q.nib_par[1] ^ s1_q.nib_par[3];
        s2_d.data  = s1_q.data;
`ifdef SEC_KEY_LOCK_EN
        s2_d.check = chk ^ key;
`else
        s2_d.check = chk;
`endif
    end

    c499_sec_stage #(.W($bits(s2_t))) u_stage2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s2_d),
        .out_valid (s2_valid),
        .out_ready (out_ready),
        .out_data  (s2_q)
    );

    assign out_valid = s2_valid;
    assign out_data  = s2_q.data;
    assign out_check = s2_q.check;
    assign busy      = s1_valid | s2_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_count <= '0;
        end else if (out_valid && out_ready) begin
            word_count <= word_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_c499_sec_encoder.sv
// Directed bench for c499_sec_encoder with an in-order scoreboard on every output transfer.
module tb_c499_sec_encoder;
    import c499_sec_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, out_valid, busy;
    logic [31:0] out_data;
    logic [7:0]  out_check;
    logic [15:0] word_count;
`ifdef SEC_KEY_LOCK_EN
    logic [7:0]  key = 8'h00;
`endif

    int          checks = 0;
    int          failures = 0;
    logic [31:0] q[$];
    logic [15:0] exp_cnt = '0;

    always #5 clk = ~clk;

    c499_sec_encoder #(.CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef SEC_KEY_LOCK_EN
        .key        (key),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_check  (out_check),
        .word_count (word_count),
        .busy       (busy)
    );

    function automatic logic [7:0] exp_check(input logic [31:0] d);
`ifdef SEC_KEY_LOCK_EN
        return sec_check(d) ^ key;
`else
        return sec_check(d);
`endif
    endfunction

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observe handshakes mid-cycle, then advance to just after the next rising edge.
    task automatic tick();
        logic [31:0] e;
        #1;
        if (out_valid && out_ready) begin
            chk("sb_occupancy", {39'd0, q.size() > 0}, 40'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_data", {8'd0, out_data}, {8'd0, e});
                chk("sb_check", {32'd0, out_check}, {32'd0, exp_check(e)});
            end
            exp_cnt++;
        end
        if (in_valid && in_ready) q.push_back(in_data);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {39'd0, out_valid}, 40'd0);
        chk("reset_out_data", {8'd0, out_data}, 40'd0);
        chk("reset_out_check", {32'd0, out_check}, 40'd0);
        chk("reset_word_count", {24'd0, word_count}, 40'd0);
        chk("reset_busy", {39'd0, busy}, 40'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("ready_after_reset", {39'd0, in_ready}, 40'd1);

        // Two-cycle latency
        in_valid = 1'b1;
        in_data = 32'h0000_0000;
        tick();
        in_valid = 1'b0;
        #1;
        chk("lat_n1_valid", {39'd0, out_valid}, 40'd0);
        tick();
        #1;
        chk("lat_n2_valid", {39'd0, out_valid}, 40'd1);
        chk("lat_n2_check", {32'd0, out_check}, 40'h00);
        tick();
        chk("lat_count", {24'd0, word_count}, 40'd1);

        // Back-to-back single-bit and all-ones words
        in_valid = 1'b1;
        in_data = 32'h0000_0001;
        tick();
        in_data = 32'h0001_0000;
        tick();
        in_data = 32'h8000_0000;
        #1;
        chk("b2b_0_check", {32'd0, out_check}, 40'h51);
        tick();
        in_data = 32'hFFFF_FFFF;
        #1;
        chk("b2b_1_check", {32'd0, out_check}, 40'h15);
        tick();
        in_valid = 1'b0;
        #1;
        chk("b2b_2_check", {32'd0, out_check}, 40'h8A);
        tick();
        #1;
        chk("b2b_3_check", {32'd0, out_check}, 40'h00);
        chk("b2b_3_data", {8'd0, out_data}, 40'hFFFF_FFFF);
        tick();

        // Backpressure: two words buffer, third waits, then simultaneous in/out with both full
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h1234_5678;
        #1;
        chk("bp_rdy0", {39'd0, in_ready}, 40'd1);
        tick();
        in_data = 32'hCAFE_F00D;
        #1;
        chk("bp_rdy1", {39'd0, in_ready}, 40'd1);
        tick();
        in_data = 32'h0BAD_BEEF;
        #1;
        chk("bp_full_rdy", {39'd0, in_ready}, 40'd0);
        chk("bp_head_data", {8'd0, out_data}, 40'h1234_5678);
        tick();
        #1;
        chk("bp_hold_data", {8'd0, out_data}, 40'h1234_5678);
        chk("bp_hold_check", {32'd0, out_check}, {32'd0, exp_check(32'h1234_5678)});
        chk("bp_hold_rdy", {39'd0, in_ready}, 40'd0);
        chk("bp_hold_busy", {39'd0, busy}, 40'd1);
        out_ready = 1'b1;
        #1;
        chk("bp_simul_rdy", {39'd0, in_ready}, 40'd1);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("bp_drained", {8'd0, 32'(q.size())}, 40'd0);
        chk("bp_idle_busy", {39'd0, busy}, 40'd0);
        chk("bp_count", {24'd0, word_count}, 40'd8);

        // Random valid/ready traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("rnd_drained", {8'd0, 32'(q.size())}, 40'd0);
        chk("rnd_count", {24'd0, word_count}, {24'd0, exp_cnt});

        // Reset with both stages full
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h1111_1111;
        tick();
        in_data = 32'h2222_2222;
        tick();
        in_valid = 1'b0;
        #1;
        chk("rst_pre_valid", {39'd0, out_valid}, 40'd1);
        rst = 1'b1;
        #1;
        chk("rst_out_valid", {39'd0, out_valid}, 40'd0);
        chk("rst_count", {24'd0, word_count}, 40'd0);
        chk("rst_busy", {39'd0, busy}, 40'd0);
        q.delete();
        exp_cnt = '0;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_release_rdy", {39'd0, in_ready}, 40'd1);

        // Counter wrap after 65535 transfers
        in_valid = 1'b1;
        begin
            int n;
            n = 0;
            while (exp_cnt != 16'hFFFF && n < 70000) begin
                in_data = 32'(n);
                tick();
                n++;
            end
        end
        chk("wrap_pre", {24'd0, word_count}, 40'hFFFF);
        tick();
        chk("wrap_zero", {24'd0, word_count}, 40'h0000);
        in_valid = 1'b0;
        repeat (3) tick();

`ifdef SEC_KEY_LOCK_EN
        key = 8'hA5;
        in_valid = 1'b1;
        in_data = 32'h0000_0001;
        tick();
        in_valid = 1'b0;
        tick();
        #1;
        chk("key_check", {32'd0, out_check}, 40'hF4);
        tick();
        repeat (2) tick();
        key = 8'h00;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
